// File: rtl/sr_pulse_conditioner_if.sv
// Button inputs and conditioned outputs for sr_pulse_conditioner.
// The design consumes the slave side; the driver of the buttons uses master.
interface sr_pulse_conditioner_if;
    logic btn_set;
    logic btn_reset;
    logic S;
    logic R;
    logic deb_set;
    logic deb_reset;
    logic conflict;

    modport master (
        output btn_set, btn_reset,
        input  S, R, deb_set, deb_reset, conflict
    );

    modport slave (
        input  btn_set, btn_reset,
        output S, R, deb_set, deb_reset, conflict
    );
endinterface

// File: rtl/sr_pulse_conditioner.sv
// Debounces two raw buttons and turns their rising edges into non-overlapping,
// fixed-width S/R pulses for a downstream NOR latch. A reset request beats a set request.
module sr_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sr_pulse_conditioner_if.slave   bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(1);

    typedef enum logic [1:0] {IDLE, SET_PULSE, RST_PULSE, GAP} state_t;

    // Channel 0 is set, channel 1 is reset.
    logic [1:0] raw;
    logic [1:0] deb;
    logic [1:0] req;

    assign raw = {bus.btn_reset, bus.btn_set};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic          deb_reg;
            logic          deb_prev_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    deb_reg      <= 1'b0;
                    deb_prev_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= raw[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_reg;
                    // Level only moves after an unbroken run of differing samples.
                    if (sync2_reg != deb_reg) begin
                        if (cnt_reg == DEB_LAST) begin
                            deb_reg <= sync2_reg;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign deb[gi] = deb_reg;
            assign req[gi] = deb_reg & ~deb_prev_reg;
        end
    endgenerate

    state_t        state_reg;
    logic [PW-1:0] pcnt_reg;
    logic          pend_set_reg;
    logic          pend_rst_reg;
    logic          s_reg;
    logic          r_reg;
    logic          conflict_reg;
    logic          set_any;
    logic          rst_any;

    assign set_any = req[0] | pend_set_reg;
    assign rst_any = req[1] | pend_rst_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pcnt_reg     <= '0;
            pend_set_reg <= 1'b0;
            pend_rst_reg <= 1'b0;
            s_reg        <= 1'b0;
            r_reg        <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            conflict_reg <= 1'b0;
            if (state_reg != IDLE) begin
                pend_set_reg <= pend_set_reg | req[0];
                pend_rst_reg <= pend_rst_reg | req[1];
            end
            case (state_reg)
                IDLE: begin
                    if (rst_any) begin
                        state_reg    <= RST_PULSE;
                        r_reg        <= 1'b1;
                        s_reg        <= 1'b0;
                        pcnt_reg     <= PULSE_LOAD;
                        pend_rst_reg <= 1'b0;
                        pend_set_reg <= 1'b0;
                        conflict_reg <= set_any;
                    end else if (set_any) begin
                        state_reg    <= SET_PULSE;
                        s_reg        <= 1'b1;
                        r_reg        <= 1'b0;
                        pcnt_reg     <= PULSE_LOAD;
                        pend_set_reg <= 1'b0;
                    end
                end
                SET_PULSE, RST_PULSE: begin
                    if (pcnt_reg == PULSE_LAST) begin
                        state_reg <= GAP;
                        s_reg     <= 1'b0;
                        r_reg     <= 1'b0;
                    end else begin
                        pcnt_reg <= pcnt_reg - 1'b1;
                    end
                end
                GAP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    s_reg     <= 1'b0;
                    r_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S         = s_reg;
    assign bus.R         = r_reg;
    assign bus.deb_set   = deb[0];
    assign bus.deb_reset = deb[1];
    assign bus.conflict  = conflict_reg;

endmodule

// File: tb/tb_sr_pulse_conditioner.sv
// Bench for sr_pulse_conditioner with short debounce/pulse lengths; a timeline
// model of the button-to-pulse behaviour predicts every output each cycle.
module tb_sr_pulse_conditioner;

    localparam int D = 4;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sr_pulse_conditioner_if ifc ();

    sr_pulse_conditioner #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Model: delayed samples, differing-run length, and a busy countdown
    // covering P pulse cycles plus one gap cycle.
    int m_s1[2], m_s2[2], m_deb[2], m_run[2], m_rose[2], m_pend[2];
    int m_busy, m_kind, m_conf;

    task automatic model_step();
        int req[2];
        int nrose[2];
        int raw[2];
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0;
                m_run[c] = 0; m_rose[c] = 0; m_pend[c] = 0;
            end
            m_busy = 0; m_kind = 0; m_conf = 0;
        end else begin
            raw[0] = (ifc.btn_set === 1'b1) ? 1 : 0;
            raw[1] = (ifc.btn_reset === 1'b1) ? 1 : 0;
            for (int c = 0; c < 2; c++) begin
                req[c]   = m_rose[c];
                nrose[c] = 0;
                if (m_s2[c] != m_deb[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == D) begin
                        m_deb[c] = m_s2[c];
                        m_run[c] = 0;
                        nrose[c] = m_deb[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c]   = m_s1[c];
                m_s1[c]   = raw[c];
                m_rose[c] = nrose[c];
            end
            m_conf = 0;
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
                for (int c = 0; c < 2; c++) m_pend[c] = m_pend[c] | req[c];
            end else if ((req[1] | m_pend[1]) != 0) begin
                m_kind = 1;
                m_busy = P + 1;
                m_conf = req[0] | m_pend[0];
                m_pend[0] = 0;
                m_pend[1] = 0;
            end else if ((req[0] | m_pend[0]) != 0) begin
                m_kind = 0;
                m_busy = P + 1;
                m_pend[0] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    function automatic logic [4:0] exp_vec();
        logic [4:0] v;
        v[4] = (m_busy > 1) && (m_kind == 0);
        v[3] = (m_busy > 1) && (m_kind == 1);
        v[2] = (m_deb[0] != 0);
        v[1] = (m_deb[1] != 0);
        v[0] = (m_conf != 0);
        return v;
    endfunction

    function automatic logic [4:0] obs_vec();
        return {ifc.S, ifc.R, ifc.deb_set, ifc.deb_reset, ifc.conflict};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ifc.btn_set = 1'b0;
        ifc.btn_reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_vec() !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state: got %b want 00000", obs_vec());
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clean_set();
        int rise_at = -1, first_s = -1, s_hi = 0, r_hi = 0;
        ifc.btn_set = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clean_set cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (ifc.deb_set === 1'b1 && rise_at < 0) rise_at = k;
            if (ifc.S === 1'b1 && first_s < 0) first_s = k;
            s_hi += int'(ifc.S);
            r_hi += int'(ifc.R);
        end
        checks++;
        if (rise_at != 2 + D) begin
            errors++;
            $display("FAIL clean_set_debounce: deb_set rose at cyc %0d want %0d", rise_at, 2 + D);
        end
        checks++;
        if (first_s != 3 + D) begin
            errors++;
            $display("FAIL clean_set_latency: S rose at cyc %0d want %0d", first_s, 3 + D);
        end
        checks++;
        if (s_hi != P || r_hi != 0) begin
            errors++;
            $display("FAIL clean_set_width: S high %0d R high %0d want %0d and 0", s_hi, r_hi, P);
        end
        ifc.btn_set = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clean_set_release cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_bounce();
        int s_hi = 0, s_rise = 0;
        logic prev_s = 1'b0;
        for (int b = 0; b < 6; b++) begin
            int hi = $urandom_range(1, 3);
            int lo = $urandom_range(1, 3);
            ifc.btn_set = 1'b1;
            for (int k = 0; k < hi + lo; k++) begin
                if (k == hi) ifc.btn_set = 1'b0;
                @(negedge clk);
                checks++;
                if (ifc.deb_set !== 1'b0 || obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL bounce_hold burst %0d: got %b want %b (deb_set must stay 0)", b, obs_vec(), exp_vec());
                end
            end
        end
        ifc.btn_set = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_settle cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (ifc.S === 1'b1 && prev_s === 1'b0) s_rise++;
            prev_s = ifc.S;
            s_hi += int'(ifc.S);
        end
        checks++;
        if (s_rise != 1 || s_hi != P) begin
            errors++;
            $display("FAIL bounce_pulse: S pulses %0d high %0d want 1 and %0d", s_rise, s_hi, P);
        end
        ifc.btn_set = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_both();
        int s_hi = 0, r_hi = 0, c_hi = 0;
        ifc.btn_set = 1'b1;
        ifc.btn_reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL both cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            s_hi += int'(ifc.S);
            r_hi += int'(ifc.R);
            c_hi += int'(ifc.conflict);
        end
        checks++;
        if (r_hi != P || s_hi != 0 || c_hi != 1) begin
            errors++;
            $display("FAIL both_resolve: R %0d S %0d conflict %0d want %0d 0 1", r_hi, s_hi, c_hi, P);
        end
        ifc.btn_set = 1'b0;
        ifc.btn_reset = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_rst_during_set();
        int s_hi = 0, r_hi = 0, c_hi = 0, last_s = -1, first_r = -1;
        ifc.btn_set = 1'b1;
        @(negedge clk);
        ifc.btn_reset = 1'b1;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL set_then_reset cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (ifc.S === 1'b1) last_s = k;
            if (ifc.R === 1'b1 && first_r < 0) first_r = k;
            s_hi += int'(ifc.S);
            r_hi += int'(ifc.R);
            c_hi += int'(ifc.conflict);
        end
        checks++;
        if (s_hi != P || r_hi != P || c_hi != 0) begin
            errors++;
            $display("FAIL set_then_reset_counts: S %0d R %0d conflict %0d want %0d %0d 0", s_hi, r_hi, c_hi, P, P);
        end
        checks++;
        if (last_s < 0 || first_r != last_s + 3) begin
            errors++;
            $display("FAIL set_then_reset_order: R starts %0d want %0d (gap then idle)", first_r, last_s + 3);
        end
        ifc.btn_set = 1'b0;
        ifc.btn_reset = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        int stray = 0;
        ifc.btn_reset = 1'b1;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL async_pre cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if (ifc.R === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL async_wait_R: got R never high want R high within 30 cycles");
        end
        #2;
        rst = 1'b1;
        ifc.btn_reset = 1'b0;
        #1;
        checks++;
        if (ifc.R !== 1'b0 || ifc.S !== 1'b0) begin
            errors++;
            $display("FAIL async_drop: got S=%b R=%b want 0 0 before next edge", ifc.S, ifc.R);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ifc.S !== 1'b0 || ifc.R !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL async_quiet: got %0d cycles with S/R high want 0", stray);
        end
    endtask

    task automatic test_held_through_reset();
        int r_hi = 0, r_after = 0;
        rst = 1'b1;
        ifc.btn_reset = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL held_reset cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            r_hi += int'(ifc.R);
        end
        checks++;
        if (r_hi != P) begin
            errors++;
            $display("FAIL held_reset_pulse: got R high %0d want %0d", r_hi, P);
        end
        ifc.btn_reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            r_after += int'(ifc.R);
        end
        checks++;
        if (r_after != 0) begin
            errors++;
            $display("FAIL held_reset_release: got R high %0d want 0", r_after);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b", k, obs_vec(), exp_vec());
            end
            if ($urandom_range(0, 7) == 0) ifc.btn_set = ~ifc.btn_set;
            if ($urandom_range(0, 9) == 0) ifc.btn_reset = ~ifc.btn_reset;
        end
        ifc.btn_set = 1'b0;
        ifc.btn_reset = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_set();
        test_bounce();
        test_both();
        test_rst_during_set();
        test_async_reset();
        test_held_through_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_pulse_conditioner.md
SR_PULSE_CONDITIONER -- requirements
Module: sr_pulse_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, sets the stable-input cycles required before a debounced level changes; legal range is at least 2.
REQ-002 Parameter PULSE_CYCLES, default 4, sets the width in clocks of each S or R pulse; legal range is at least 1.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-high reset.
REQ-005 Port btn_set  input  1  is the raw, asynchronous, bouncing set button.
REQ-006 Port btn_reset  input  1  is the raw, asynchronous, bouncing reset button.
REQ-007 Port S  output  1  is the set drive to the downstream NOR SR latch (active-high; 0 = hold).
REQ-008 Port R  output  1  is the reset drive to the downstream NOR SR latch.
REQ-009 Port deb_set  output  1  is the debounced btn_set level.
REQ-010 Port deb_reset  output  1  is the debounced btn_reset level.
REQ-011 Port conflict  output  1  is a one-cycle pulse flagging that a set request was dropped.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Per channel, a counter of width $clog2(DEBOUNCE_CYCLES) SHALL count cycles where the synced value differs from the debounced level, and clear when they are equal.
REQ-014 When the counter is DEBOUNCE_CYCLES-1 and the values still differ, the debounced level SHALL take the synced value and the counter SHALL clear, so the level changes after exactly DEBOUNCE_CYCLES consecutive differing cycles.
REQ-015 A rising edge on a debounced level SHALL generate one request event for that channel; falling edges SHALL generate nothing.
REQ-016 The FSM SHALL have the states IDLE, SET_PULSE, RST_PULSE and GAP.
REQ-017 In IDLE with a reset request (new or pending), the FSM SHALL go to RST_PULSE; otherwise, with a set request, it SHALL go to SET_PULSE; otherwise it SHALL stay in IDLE.
REQ-018 In SET_PULSE, S=1 and R=0 SHALL hold for exactly PULSE_CYCLES clocks, then the FSM SHALL go to GAP.
REQ-019 In RST_PULSE, R=1 and S=0 SHALL hold for exactly PULSE_CYCLES clocks, then the FSM SHALL go to GAP.
REQ-020 In GAP, S=R=0 SHALL hold for one clock, then the FSM SHALL return to IDLE (break-before-make).
REQ-021 S and R SHALL be registered FSM outputs, and S=R=1 SHALL never occur.
REQ-022 Latency: S or R SHALL assert on the first clock edge after the debounced level rises, provided the FSM is in IDLE.
REQ-023 A request arriving outside IDLE SHALL set a one-deep pending flag for its channel; further requests on that channel while pending SHALL merge into it.
REQ-024 The pending flag SHALL clear in the cycle its pulse state is entered.
REQ-025 A set and a reset request (new or pending) present together in IDLE SHALL be resolved as reset wins: the set request and set pending flag are discarded, and conflict pulses high for one cycle.
REQ-026 A set request in IDLE with nothing else present SHALL produce no conflict.
REQ-027 The pulse-width counter width SHALL be $clog2(PULSE_CYCLES+1), and the counter SHALL reload on entry to each pulse state.

Reset
REQ-028 While rst=1, asynchronously: synchronizer flops, debounce counters, deb_set and deb_reset SHALL be 0.
REQ-029 While rst=1, asynchronously: pending flags, S, R and conflict SHALL be 0, and the FSM SHALL be in IDLE.
REQ-030 Reset asserted mid-pulse SHALL drop S/R to 0 immediately, with no GAP cycle and no retained pending requests.
REQ-031 A button held through reset release SHALL produce exactly one pulse once its debounce completes.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2)
REQ-032 Test: btn_set rises cleanly. Required: deb_set rises 4 clocks after the synced rise; S is high for 2 clocks; 1 GAP clock follows; R stays 0 throughout.
REQ-033 Test: btn_set bounces with high runs of 1-3 clocks, then stays high. Required: no deb_set change during bouncing; one S pulse after 4 stable clocks.
REQ-034 Test: both buttons rise in the same clock. Required: a 2-clock R pulse, no S pulse, and conflict high for 1 clock.
REQ-035 Test: a reset request arrives during SET_PULSE. Required: the S pulse completes, then GAP, then a 2-clock R pulse; conflict stays 0.
REQ-036 Test: rst asserted while R=1. Required: R=0 asynchronously before the next clock edge; after release with buttons low, the outputs stay 0.
REQ-037 Test: btn_reset held high across reset release. Required: exactly one R pulse after debounce, and none after the button is released.
